// File: rtl/bus_signals_demux_if.sv
// Bus bundle for the 1-to-2 registered demultiplexer: one producer stream in,
// two consumer streams out, plus per-side occupancy.
interface bus_signals_demux_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
);
    logic [WIDTH-1:0]         in_1;
    logic                     in_3;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_1;
    logic                     out_1_valid;
    logic                     out_1_ready;
    logic [WIDTH-1:0]         out_2;
    logic                     out_2_valid;
    logic                     out_2_ready;
    logic [$clog2(DEPTH):0]   count_1;
    logic [$clog2(DEPTH):0]   count_2;

    modport master (
        output in_1, in_3, in_valid, out_1_ready, out_2_ready,
        input  in_ready, out_1, out_1_valid, out_2, out_2_valid, count_1, count_2
    );

    modport slave (
        input  in_1, in_3, in_valid, out_1_ready, out_2_ready,
        output in_ready, out_1, out_1_valid, out_2, out_2_valid, count_1, count_2
    );
endinterface

// File: rtl/bus_signals_demux.sv
// Registered 1-to-2 bus demultiplexer: each beat is steered by in_3 into one of
// two independent DEPTH-entry FIFOs, so one stalled consumer never blocks the other.
module bus_signals_demux #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    bus_signals_demux_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Index 0 holds the out_1 side, index 1 the out_2 side.
    logic [WIDTH-1:0] mem_r    [2][DEPTH];
    logic [AW-1:0]    wr_ptr_r [2];
    logic [AW-1:0]    rd_ptr_r [2];
    logic [CW-1:0]    cnt_r    [2];

    logic [1:0] full_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic [1:0] ready_s;
    logic       in_ready_s;

    // Handshake decode: in_ready looks only at the selected side's fullness.
    always_comb begin
        ready_s = {bus.out_2_ready, bus.out_1_ready};
        for (int i = 0; i < 2; i++) begin
            full_s[i] = (cnt_r[i] == FULL_CNT);
            pop_s[i]  = (cnt_r[i] != {CW{1'b0}}) & ready_s[i];
        end
        if (!rst_n) begin
            in_ready_s = 1'b0;
        end else if (bus.in_3) begin
            in_ready_s = ~full_s[1];
        end else begin
            in_ready_s = ~full_s[0];
        end
        push_s[0] = bus.in_valid & in_ready_s & ~bus.in_3;
        push_s[1] = bus.in_valid & in_ready_s &  bus.in_3;
    end

    // FIFO state: storage, pointers and occupancy for both sides.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_r[i][j] <= {WIDTH{1'b0}};
                end
                wr_ptr_r[i] <= {AW{1'b0}};
                rd_ptr_r[i] <= {AW{1'b0}};
                cnt_r[i]    <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= bus.in_1;
                    wr_ptr_r[i]           <= wr_ptr_r[i] + AW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CW'(1);
                    2'b01:   cnt_r[i] <= cnt_r[i] - CW'(1);
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_1       = mem_r[0][rd_ptr_r[0]];
    assign bus.out_1_valid = (cnt_r[0] != {CW{1'b0}});
    assign bus.count_1     = cnt_r[0];
    assign bus.out_2       = mem_r[1][rd_ptr_r[1]];
    assign bus.out_2_valid = (cnt_r[1] != {CW{1'b0}});
    assign bus.count_2     = cnt_r[1];
endmodule

// File: tb/tb_bus_signals_demux.sv
// Directed bench for bus_signals_demux: queue-based reference model compared on
// every falling edge, plus hand-computed literal checks per scenario.
module tb_bus_signals_demux;
    localparam int W = 4;
    localparam int D = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   run_chk = 1'b0;

    int unsigned q1[$];
    int unsigned q2[$];
    int unsigned log2[$];

    bus_signals_demux_if #(.WIDTH(W), .DEPTH(D)) bus ();

    bus_signals_demux #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input int d, input logic r1, input logic r2);
        bus.in_valid    = v;
        bus.in_3        = s;
        bus.in_1        = W'(d);
        bus.out_1_ready = r1;
        bus.out_2_ready = r2;
    endtask

    // Reference model: two bounded queues updated on each rising edge.
    always @(posedge clk) begin
        bit p1, p2, acc;
        if (rst_n) begin
            p1  = bus.out_1_ready && (q1.size() > 0);
            p2  = bus.out_2_ready && (q2.size() > 0);
            acc = bus.in_valid && (bus.in_3 ? (q2.size() < D) : (q1.size() < D));
            if (p1) void'(q1.pop_front());
            if (p2) begin
                log2.push_back(q2[0]);
                void'(q2.pop_front());
            end
            if (acc) begin
                if (bus.in_3) q2.push_back(int'(bus.in_1));
                else          q1.push_back(int'(bus.in_1));
            end
        end
    end

    always @(negedge rst_n) begin
        q1.delete();
        q2.delete();
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("count_1", int'(bus.count_1), q1.size());
            chk("count_2", int'(bus.count_2), q2.size());
            chk("out_1_valid", int'(bus.out_1_valid), int'(q1.size() > 0));
            chk("out_2_valid", int'(bus.out_2_valid), int'(q2.size() > 0));
            chk("in_ready", int'(bus.in_ready),
                int'(rst_n && (bus.in_3 ? (q2.size() < D) : (q1.size() < D))));
            if (q1.size() > 0) chk("out_1", int'(bus.out_1), int'(q1[0]));
            if (q2.size() > 0) chk("out_2", int'(bus.out_2), int'(q2[0]));
            if (!rst_n) begin
                chk("rst_out_1", int'(bus.out_1), 0);
                chk("rst_out_2", int'(bus.out_2), 0);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_chk = 1'b1;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(15)),
                  1'($urandom_range(1)), 1'($urandom_range(1)));
            #1;
            chk("rst_in_ready", int'(bus.in_ready), 0);
        end
        tick();
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", int'(bus.in_ready), 1);
        chk("rel_count_1", int'(bus.count_1), 0);

        // Steering
        tick(); drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b1);
        tick();
        chk("steer_v1", int'(bus.out_1_valid), 1);
        chk("steer_d1", int'(bus.out_1), 4'hA);
        drive(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        tick();
        chk("steer_v2", int'(bus.out_2_valid), 1);
        chk("steer_d2", int'(bus.out_2), 4'h5);
        chk("steer_c1", int'(bus.count_1), 0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        chk("steer_c2", int'(bus.count_2), 0);

        // Backpressure and full on side 1
        drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
        tick(); drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b1);
        tick(); drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        tick();
        chk("full_c1", int'(bus.count_1), 2);
        chk("full_rdy0", int'(bus.in_ready), 0);
        drive(1'b0, 1'b1, 4'h3, 1'b0, 1'b1);
        #1;
        chk("full_rdy1", int'(bus.in_ready), 1);
        drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        tick();
        chk("held_c1", int'(bus.count_1), 2);
        chk("held_head", int'(bus.out_1), 4'h1);
        drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        tick();
        chk("drain_head2", int'(bus.out_1), 4'h2);
        tick();
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("drain_head3", int'(bus.out_1), 4'h3);
        tick();
        chk("drain_c1", int'(bus.count_1), 0);

        // Stream 0..F to side 2 with continuous pops
        log2.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, i, 1'b1, 1'b1);
            tick();
            chk("stream_cnt_le1", int'(bus.count_2 <= 1), 1);
        end
        drive(1'b0, 1'b1, 0, 1'b1, 1'b1);
        tick(); tick();
        chk("stream_len", log2.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < log2.size()) chk("stream_ord", int'(log2[i]), i);
        end

        // Side 1 full and stalled while side 2 streams
        drive(1'b1, 1'b0, 4'h7, 1'b0, 1'b1);
        tick(); drive(1'b1, 1'b0, 4'h8, 1'b0, 1'b1);
        log2.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(1'b1, 1'b1, 9 + i, 1'b0, 1'b1);
        end
        tick(); drive(1'b0, 1'b1, 0, 1'b0, 1'b1);
        tick(); tick();
        chk("xside_len", log2.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log2.size()) chk("xside_ord", int'(log2[i]), (9 + i) % 16);
        end
        chk("xside_c1", int'(bus.count_1), 2);
        chk("xside_head", int'(bus.out_1), 4'h7);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick(); tick(); tick();
        chk("xside_drain", int'(bus.count_1), 0);

        // Reset in the middle of traffic
        drive(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
        tick(); drive(1'b1, 1'b1, 4'hD, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("pre_rst_c1", int'(bus.count_1), 1);
        chk("pre_rst_c2", int'(bus.count_2), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v1", int'(bus.out_1_valid), 0);
        chk("mid_rst_v2", int'(bus.out_2_valid), 0);
        chk("mid_rst_c1", int'(bus.count_1), 0);
        chk("mid_rst_c2", int'(bus.count_2), 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick(); tick();
        chk("post_rst_v1", int'(bus.out_1_valid), 0);
        chk("post_rst_v2", int'(bus.out_2_valid), 0);

        run_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
